// File: rtl/lcd_rx_monitor.sv
// -----------------------------------------------------------------------------
// lcd_rx_monitor
//   Receive-side checker for a parallel RGB565 LCD interface tapped in loopback
//   on the generator's PixelClk. It measures line/frame geometry, locks when
//   the geometry matches the expected panel size for LOCK_FRAMES consecutive
//   frames, flags timing faults, and can capture one pixel for self-test.
//
//   Optional feature macro: LCD_RX_PROBE_EN (probe capture compiled in when
//   defined; when undefined probe_rgb/probe_valid are tied to 0).
//
// Ports
//   PixelClk, nRST           pixel clock (rising edge), async active-low reset
//   LCD_DE/HSYNC/VSYNC       panel controls (DE high, syncs active low)
//   LCD_R/G/B                5/6/5 pixel data
//   probe_x, probe_y         0-based active-area coordinate to capture
//   meas_htotal/width        cycles per line / DE-high cycles of last line
//   meas_vtotal/height       lines per frame / active lines of last frame
//   frame_done               one-cycle pulse when frame measurements update
//   locked, err_sticky       geometry lock, sticky fault flag
//   probe_rgb, probe_valid   captured pixel and its update pulse
//
// Pipeline: inputs -> S1 -> S2; edge flags registered from S1/S2; the
// processing stage acts on the edge flags and S2 data, so outputs move two
// clocks after the input sample.
// -----------------------------------------------------------------------------
module lcd_rx_monitor #(
  parameter logic [15:0] EXP_WIDTH   = 16'd800,
  parameter logic [15:0] EXP_HEIGHT  = 16'd480,
  parameter logic [3:0]  LOCK_FRAMES = 4'd2,
  parameter logic [15:0] TIMEOUT     = 16'hFFFF
) (
  input  logic        PixelClk,
  input  logic        nRST,
  input  logic        LCD_DE,
  input  logic        LCD_HSYNC,
  input  logic        LCD_VSYNC,
  input  logic [4:0]  LCD_R,
  input  logic [5:0]  LCD_G,
  input  logic [4:0]  LCD_B,
  input  logic [15:0] probe_x,
  input  logic [15:0] probe_y,
  output logic [15:0] meas_htotal,
  output logic [15:0] meas_width,
  output logic [15:0] meas_vtotal,
  output logic [15:0] meas_height,
  output logic        frame_done,
  output logic        locked,
  output logic        err_sticky,
  output logic [15:0] probe_rgb,
  output logic        probe_valid
);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

  // ---------------- input capture and edge detection ----------------
  logic de_s1_q, hs_s1_q, vs_s1_q, de_s1_d, hs_s1_d, vs_s1_d;
  logic de_s2_q, hs_s2_q, vs_s2_q, de_s2_d, hs_s2_d, vs_s2_d;
  logic line_start_q, frame_start_q, de_fall_q;
  logic line_start_d, frame_start_d, de_fall_d;

  // Two-stage capture; falling edges seen as S2 high while S1 low.
  always_comb begin
    de_s1_d       = LCD_DE;
    hs_s1_d       = LCD_HSYNC;
    vs_s1_d       = LCD_VSYNC;
    de_s2_d       = de_s1_q;
    hs_s2_d       = hs_s1_q;
    vs_s2_d       = vs_s1_q;
    line_start_d  = hs_s2_q & ~hs_s1_q;
    frame_start_d = vs_s2_q & ~vs_s1_q;
    de_fall_d     = de_s2_q & ~de_s1_q;
  end

  // Capture and edge-flag registers.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      de_s1_q       <= 1'b0;
      hs_s1_q       <= 1'b0;
      vs_s1_q       <= 1'b0;
      de_s2_q       <= 1'b0;
      hs_s2_q       <= 1'b0;
      vs_s2_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      de_fall_q     <= 1'b0;
    end else begin
      de_s1_q       <= de_s1_d;
      hs_s1_q       <= hs_s1_d;
      vs_s1_q       <= vs_s1_d;
      de_s2_q       <= de_s2_d;
      hs_s2_q       <= hs_s2_d;
      vs_s2_q       <= vs_s2_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      de_fall_q     <= de_fall_d;
    end
  end

  // ---------------- geometry counters and measurements ----------------
  logic [15:0] hcnt_q, dcnt_q, vcnt_q, acnt_q, hcnt_d, dcnt_d, vcnt_d, acnt_d;
  logic [15:0] meas_htotal_q, meas_width_q, meas_vtotal_q, meas_height_q;
  logic [15:0] meas_htotal_d, meas_width_d, meas_vtotal_d, meas_height_d;
  logic        line_act_q, line_act_d, htot_seen_q, htot_seen_d;
  logic        acnt_inc_s;
  state_t      state_q, state_d;

  // Counter updates; a line start coinciding with a frame start is counted
  // as line 1 of the new frame.
  always_comb begin
    hcnt_d      = line_start_q ? 16'd1 : sat_inc(hcnt_q);
    htot_seen_d = htot_seen_q | line_start_q;
    // The first line start after reset has no preceding line to measure.
    meas_htotal_d = (line_start_q && htot_seen_q) ? hcnt_q : meas_htotal_q;
    dcnt_d = line_start_q ? {15'd0, de_s2_q} :
             (de_s2_q ? sat_inc(dcnt_q) : dcnt_q);
    meas_width_d = de_fall_q ? dcnt_q : meas_width_q;
    acnt_inc_s   = de_fall_q & ~line_act_q;
    line_act_d   = line_start_q ? 1'b0 : (de_fall_q ? 1'b1 : line_act_q);
    vcnt_d = frame_start_q ? {15'd0, line_start_q} :
             (line_start_q ? sat_inc(vcnt_q) : vcnt_q);
    acnt_d = frame_start_q ? 16'd0 : (acnt_inc_s ? sat_inc(acnt_q) : acnt_q);
    // The partial frame seen while searching is not reported.
    meas_vtotal_d = (frame_start_q && (state_q != ST_SEARCH)) ? vcnt_q : meas_vtotal_q;
    meas_height_d = (frame_start_q && (state_q != ST_SEARCH)) ? acnt_q : meas_height_q;
  end

  // Counter and measurement registers.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      hcnt_q        <= 16'd0;
      dcnt_q        <= 16'd0;
      vcnt_q        <= 16'd0;
      acnt_q        <= 16'd0;
      line_act_q    <= 1'b0;
      htot_seen_q   <= 1'b0;
      meas_htotal_q <= 16'd0;
      meas_width_q  <= 16'd0;
      meas_vtotal_q <= 16'd0;
      meas_height_q <= 16'd0;
    end else begin
      hcnt_q        <= hcnt_d;
      dcnt_q        <= dcnt_d;
      vcnt_q        <= vcnt_d;
      acnt_q        <= acnt_d;
      line_act_q    <= line_act_d;
      htot_seen_q   <= htot_seen_d;
      meas_htotal_q <= meas_htotal_d;
      meas_width_q  <= meas_width_d;
      meas_vtotal_q <= meas_vtotal_d;
      meas_height_q <= meas_height_d;
    end
  end

  // ---------------- lock FSM ----------------
  logic [3:0] match_cnt_q, match_cnt_d;
  logic       locked_q, locked_d, err_q, err_d, frame_done_q, frame_done_d;
  logic       match_s, timeout_s, lock_reach_s;

  // Frame comparison uses values from before this cycle's frame-start update,
  // so meas_vtotal_q is the previous frame's line count.
  assign match_s      = (meas_width_q == EXP_WIDTH) && (acnt_q == EXP_HEIGHT) &&
                        (vcnt_q == meas_vtotal_q);
  assign timeout_s    = ~line_start_q && (hcnt_d == TIMEOUT);
  assign lock_reach_s = ({1'b0, match_cnt_q} + 5'd1) >= {1'b0, LOCK_FRAMES};

  // State register.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_SEARCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a timeout overrides any frame-start transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SEARCH:  state_d = frame_start_q ? ST_MEASURE : ST_SEARCH;
      ST_MEASURE: state_d = (frame_start_q && match_s && lock_reach_s) ? ST_LOCKED : ST_MEASURE;
      ST_LOCKED:  state_d = (frame_start_q && !match_s) ? ST_MEASURE : ST_LOCKED;
      default:    state_d = ST_SEARCH;
    endcase
    if (timeout_s) begin
      state_d = ST_SEARCH;
    end else begin
      state_d = state_d;
    end
  end

  // FSM outputs (registered below so locked and frame_done move together).
  always_comb begin
    if (state_d != ST_MEASURE) begin
      match_cnt_d = 4'd0;
    end else if (frame_start_q && (state_q == ST_MEASURE)) begin
      match_cnt_d = match_s ? (match_cnt_q + 4'd1) : 4'd0;
    end else begin
      match_cnt_d = match_cnt_q;
    end
    locked_d     = (state_d == ST_LOCKED);
    frame_done_d = frame_start_q && (state_q != ST_SEARCH);
    err_d        = err_q | ((state_q == ST_LOCKED) &&
                            ((frame_start_q && !match_s) || timeout_s));
  end

  // FSM output registers.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      match_cnt_q  <= 4'd0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      match_cnt_q  <= match_cnt_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign meas_htotal = meas_htotal_q;
  assign meas_width  = meas_width_q;
  assign meas_vtotal = meas_vtotal_q;
  assign meas_height = meas_height_q;
  assign frame_done  = frame_done_q;
  assign locked      = locked_q;
  assign err_sticky  = err_q;

  // ---------------- probe capture ----------------
`ifdef LCD_RX_PROBE_EN
  logic [15:0] rgb_s1_q, rgb_s1_d, rgb_s2_q, rgb_s2_d, probe_rgb_q, probe_rgb_d;
  logic [15:0] probe_px_s, probe_py_s;
  logic        probe_valid_q, probe_valid_d, probe_hit_s;

  // Pixel position is the DE count before this pixel and the active-line
  // index within the frame; both restart on the coinciding sync edge.
  always_comb begin
    rgb_s1_d      = {LCD_R, LCD_G, LCD_B};
    rgb_s2_d      = rgb_s1_q;
    probe_px_s    = line_start_q ? 16'd0 : dcnt_q;
    probe_py_s    = frame_start_q ? 16'd0 : acnt_q;
    probe_hit_s   = de_s2_q && (probe_px_s == probe_x) && (probe_py_s == probe_y);
    probe_valid_d = probe_hit_s;
    probe_rgb_d   = probe_hit_s ? rgb_s2_q : probe_rgb_q;
  end

  // Pixel data pipeline and probe registers.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      rgb_s1_q      <= 16'd0;
      rgb_s2_q      <= 16'd0;
      probe_rgb_q   <= 16'd0;
      probe_valid_q <= 1'b0;
    end else begin
      rgb_s1_q      <= rgb_s1_d;
      rgb_s2_q      <= rgb_s2_d;
      probe_rgb_q   <= probe_rgb_d;
      probe_valid_q <= probe_valid_d;
    end
  end

  assign probe_rgb   = probe_rgb_q;
  assign probe_valid = probe_valid_q;
`else
  logic unused_probe_s;
  assign unused_probe_s = ^{probe_x, probe_y, LCD_R, LCD_G, LCD_B};
  assign probe_rgb      = 16'd0;
  assign probe_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_rx_monitor.sv
// Testbench for lcd_rx_monitor: scaled-down panel timing (htotal 30, 20 DE
// cycles, vtotal 16, 12 active lines) with random pixel data, random probe
// coordinates and random short frames, checked every cycle against a
// behavioural model, plus literal expectations at scenario boundaries.
module tb_lcd_rx_monitor;

  localparam int HTOT  = 30;
  localparam int VTOT  = 16;
  localparam int EXPW  = 20;
  localparam int EXPH  = 12;
  localparam int LOCKF = 2;
  localparam int TMO   = 100;

  logic        PixelClk = 1'b0;
  logic        nRST;
  logic        LCD_DE, LCD_HSYNC, LCD_VSYNC;
  logic [4:0]  LCD_R;
  logic [5:0]  LCD_G;
  logic [4:0]  LCD_B;
  logic [15:0] probe_x, probe_y;
  logic [15:0] meas_htotal, meas_width, meas_vtotal, meas_height, probe_rgb;
  logic        frame_done, locked, err_sticky, probe_valid;

  int errors = 0;
  int checks = 0;

  lcd_rx_monitor #(
    .EXP_WIDTH(16'd20), .EXP_HEIGHT(16'd12), .LOCK_FRAMES(4'd2), .TIMEOUT(16'd100)
  ) dut (
    .PixelClk(PixelClk), .nRST(nRST), .LCD_DE(LCD_DE), .LCD_HSYNC(LCD_HSYNC),
    .LCD_VSYNC(LCD_VSYNC), .LCD_R(LCD_R), .LCD_G(LCD_G), .LCD_B(LCD_B),
    .probe_x(probe_x), .probe_y(probe_y), .meas_htotal(meas_htotal),
    .meas_width(meas_width), .meas_vtotal(meas_vtotal), .meas_height(meas_height),
    .frame_done(frame_done), .locked(locked), .err_sticky(err_sticky),
    .probe_rgb(probe_rgb), .probe_valid(probe_valid)
  );

  always #5 PixelClk = ~PixelClk;

  // ---------------- behavioural model ----------------
  // Samples are {DE, HSYNC, VSYNC, RGB}. The DUT reacts to a sample two
  // clocks after taking it, so the model consumes the sample from two edges
  // back, with the one before it as the edge reference.
  logic [18:0] p0, p1, p2;
  int m_h, m_d, m_v, m_a, m_htot, m_width, m_vtot, m_height, m_mode, m_matches;
  bit m_act, m_seen, m_fd, m_err, m_pval;
  logic [15:0] m_prgb;

  function automatic int sat(input int v);
    sat = (v > 65535) ? 65535 : v;
  endfunction

  task automatic model_reset();
    p0 = '0; p1 = '0; p2 = '0;
    m_h = 0; m_d = 0; m_v = 0; m_a = 0; m_htot = 0; m_width = 0;
    m_vtot = 0; m_height = 0; m_mode = 0; m_matches = 0;
    m_act = 0; m_seen = 0; m_fd = 0; m_err = 0; m_pval = 0; m_prgb = 16'd0;
  endtask

  // m_mode: 0 = searching, 1 = measuring, 2 = locked
  task automatic model_step(input logic [18:0] cur, input logic [18:0] prv);
    bit ls, fs, df, de, match, timeout, act_inc;
    int new_h;
    ls = prv[17] && !cur[17];
    fs = prv[16] && !cur[16];
    df = prv[18] && !cur[18];
    de = cur[18];
    m_fd = 0;
    m_pval = 0;
    new_h   = ls ? 1 : sat(m_h + 1);
    timeout = !ls && (new_h == TMO);
    match   = (m_width == EXPW) && (m_a == EXPH) && (m_v == m_vtot);
`ifdef LCD_RX_PROBE_EN
    if (de && ((ls ? 0 : m_d) == int'(probe_x)) && ((fs ? 0 : m_a) == int'(probe_y))) begin
      m_prgb = cur[15:0];
      m_pval = 1;
    end
`endif
    if (ls && m_seen) m_htot = m_h;
    if (ls) m_seen = 1;
    if (df) m_width = m_d;
    act_inc = df && !m_act;
    m_d   = ls ? int'(de) : (de ? sat(m_d + 1) : m_d);
    m_act = ls ? 0 : (df ? 1 : m_act);
    if (fs) begin
      if (m_mode == 0) begin
        m_mode = 1;
      end else begin
        m_fd = 1;
        m_vtot = m_v;
        m_height = m_a;
        if (m_mode == 1) begin
          if (match) begin
            m_matches++;
            if (m_matches >= LOCKF) m_mode = 2;
          end else begin
            m_matches = 0;
          end
        end else if (!match) begin
          m_err = 1;
          m_mode = 1;
          m_matches = 0;
        end
      end
      m_v = ls ? 1 : 0;
      m_a = 0;
    end else begin
      if (ls) m_v = sat(m_v + 1);
      if (act_inc) m_a = sat(m_a + 1);
    end
    m_h = new_h;
    if (timeout) begin
      if (m_mode == 2) m_err = 1;
      m_mode = 0;
    end
    if (m_mode != 1) m_matches = 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge PixelClk or negedge nRST);
      if (!nRST) begin
        model_reset();
      end else begin
        model_step(p1, p2);
        p2 = p1;
        p1 = p0;
        p0 = {LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B};
      end
    end
  end

  // ---------------- compare process and event counters ----------------
  int fd_count = 0, pv_count = 0, lock_at_fd = -1;
  bit locked_prev = 0;
  logic [83:0] exp_v, act_v;

  initial begin
    forever begin
      @(negedge PixelClk);
      if (nRST === 1'b1) begin
        exp_v = {16'(m_htot), 16'(m_width), 16'(m_vtot), 16'(m_height),
                 m_fd, (m_mode == 2), m_err, m_prgb, m_pval};
        act_v = {meas_htotal, meas_width, meas_vtotal, meas_height,
                 frame_done, locked, err_sticky, probe_rgb, probe_valid};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL cycle_model t=%0t got htot=%0d w=%0d vtot=%0d h=%0d fd=%b lk=%b err=%b rgb=%h pv=%b required htot=%0d w=%0d vtot=%0d h=%0d fd=%b lk=%b err=%b rgb=%h pv=%b",
                   $time, act_v[83:68], act_v[67:52], act_v[51:36], act_v[35:20],
                   act_v[19], act_v[18], act_v[17], act_v[16:1], act_v[0],
                   exp_v[83:68], exp_v[67:52], exp_v[51:36], exp_v[35:20],
                   exp_v[19], exp_v[18], exp_v[17], exp_v[16:1], exp_v[0]);
        end
        if (frame_done) fd_count++;
        if (probe_valid) pv_count++;
        if (locked && !locked_prev) lock_at_fd = fd_count;
        locked_prev = locked;
      end else begin
        locked_prev = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // ---------------- stimulus ----------------
  bit force_pix = 0;

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge PixelClk);
      LCD_HSYNC = 1'b1;
      LCD_VSYNC = 1'b1;
      LCD_DE    = 1'b0;
    end
  endtask

  // One frame; HSYNC and VSYNC fall together at line 0, pixel 0.
  task automatic drive_frame(input int act, input int max_cyc);
    int n;
    logic [15:0] pix;
    n = 0;
    for (int v = 0; v < VTOT; v++) begin
      for (int h = 0; h < HTOT; h++) begin
        if (n < max_cyc) begin
          @(negedge PixelClk);
          LCD_HSYNC = (h >= 3);
          LCD_VSYNC = (v >= 2);
          LCD_DE    = (v >= 2) && (v < 2 + act) && (h >= 5) && (h < 5 + EXPW);
          pix = 16'($urandom);
          if (force_pix && (h - 5 == 10) && (v - 2 == 5)) pix = 16'hA5C3;
          {LCD_R, LCD_G, LCD_B} = pix;
          n++;
        end
      end
    end
  endtask

  localparam int FULL = 1 << 20;
  int fd_ref, pv_ref;

  initial begin
    nRST = 1'b0;
    LCD_HSYNC = 1'b1; LCD_VSYNC = 1'b1; LCD_DE = 1'b0;
    {LCD_R, LCD_G, LCD_B} = 16'd0;
    probe_x = 16'd10; probe_y = 16'd5;
    repeat (3) @(negedge PixelClk);
    #1;
    check("rst_htotal", 32'(meas_htotal), 32'd0);
    check("rst_vtotal", 32'(meas_vtotal), 32'd0);
    check("rst_flags", {28'd0, frame_done, locked, err_sticky, probe_valid}, 32'd0);
    check("rst_probe_rgb", 32'(probe_rgb), 32'd0);
    @(negedge PixelClk);
    nRST = 1'b1;
    idle(10);

    // Nominal geometry: lock at the third frame_done.
    repeat (4) drive_frame(EXPH, FULL);
    check("nom_htotal", 32'(meas_htotal), 32'd30);
    check("nom_width", 32'(meas_width), 32'd20);
    check("nom_vtotal", 32'(meas_vtotal), 32'd16);
    check("nom_height", 32'(meas_height), 32'd12);
    check("nom_locked", 32'(locked), 32'd1);
    check("nom_err", 32'(err_sticky), 32'd0);
    check("lock_at_fd", 32'(lock_at_fd), 32'd3);

    // One short frame drops lock; two good frames relock.
    drive_frame(EXPH - 1, FULL);
    drive_frame(EXPH, FULL);
    check("short_unlock", 32'(locked), 32'd0);
    check("short_err", 32'(err_sticky), 32'd1);
    check("short_height", 32'(meas_height), 32'd11);
    repeat (2) drive_frame(EXPH, FULL);
    check("relock", 32'(locked), 32'd1);
    check("relock_err", 32'(err_sticky), 32'd1);

    // HSYNC stops: timeout drops lock; restart searches, then relocks.
    fd_ref = fd_count;
    idle(TMO + 20);
    check("tmo_locked", 32'(locked), 32'd0);
    check("tmo_err", 32'(err_sticky), 32'd1);
    drive_frame(EXPH, FULL);
    check("search_no_fd", 32'(fd_count - fd_ref), 32'd0);
    repeat (2) drive_frame(EXPH, FULL);
    check("tmo_relock", 32'(locked), 32'd1);

    // Probe at (10,5) with a known pixel, then an out-of-area coordinate.
    force_pix = 1;
    pv_ref = pv_count;
    repeat (2) drive_frame(EXPH, FULL);
`ifdef LCD_RX_PROBE_EN
    check("probe_count", 32'(pv_count - pv_ref), 32'd2);
    check("probe_rgb", 32'(probe_rgb), 32'h0000A5C3);
`else
    check("probe_count_off", 32'(pv_count - pv_ref), 32'd0);
`endif
    probe_x = 16'd900;
    pv_ref = pv_count;
    drive_frame(EXPH, FULL);
    check("probe_outside", 32'(pv_count - pv_ref), 32'd0);
    force_pix = 0;

    // Random frames and probe coordinates, checked by the model.
    repeat (6) begin
      probe_x = 16'($urandom_range(0, 24));
      probe_y = 16'($urandom_range(0, 13));
      drive_frame($urandom_range(EXPH - 2, EXPH), FULL);
    end

    // Mid-frame reset while locked.
    probe_x = 16'd10; probe_y = 16'd5;
    repeat (3) drive_frame(EXPH, FULL);
    check("pre_rst_locked", 32'(locked), 32'd1);
    drive_frame(EXPH, 200);
    #2 nRST = 1'b0;
    #1;
    check("mid_rst_meas", 32'(meas_htotal | meas_width | meas_vtotal | meas_height), 32'd0);
    check("mid_rst_flags", {28'd0, frame_done, locked, err_sticky, probe_valid}, 32'd0);
    check("mid_rst_rgb", 32'(probe_rgb), 32'd0);
    repeat (2) @(negedge PixelClk);
    LCD_HSYNC = 1'b1; LCD_VSYNC = 1'b1; LCD_DE = 1'b0;
    @(negedge PixelClk);
    nRST = 1'b1;
    idle(5);
    fd_ref = fd_count;
    drive_frame(EXPH, FULL);
    check("post_rst_no_fd", 32'(fd_count - fd_ref), 32'd0);
    drive_frame(EXPH, FULL);
    check("post_rst_fd", 32'(fd_count - fd_ref), 32'd1);
    check("coincident_vtotal", 32'(meas_vtotal), 32'd16);
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
